led_runner_ctrl: RTL and testbench

Parametrised running-light controller driving the board LED bank from the slide switches. It is the next generation of the fixed 16-LED, three-speed `controller`. The LED width, mode-select width and per-mode step periods are parameters. New over the previous block: a direction input, a pause input, a one-cycle step strobe, and a synchroniser on the switch inputs. It sits directly between the board pins (`SW`, `LD`) and the system clock.

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/sw_sync.sv | 41 ++++
 rtl/led_runner_ctrl.sv | 111 +++++++++++
 tb/tb_led_runner_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_ctrl_pkg
//   Shared definitions for the running-light controller: mode encodings,
//   the controller state enum and a helper for sizing the step prescaler.
// ---------------------------------------------------------------------------
package led_ctrl_pkg;

  // Mode encodings as applied on MODE (the synchronised SW value).
  localparam logic [1:0] MODE_STOP = 2'd0;
  localparam logic [1:0] MODE_1    = 2'd1;
  localparam logic [1:0] MODE_2    = 2'd2;
  localparam logic [1:0] MODE_3    = 2'd3;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    PAUSE
  } state_e;

  // Largest of three step periods; used to size the prescaler counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : led_ctrl_pkg

// File: rtl/sw_sync.sv
// ---------------------------------------------------------------------------
// sw_sync
//   Two-flop synchroniser for a W-bit bus that is asynchronous to clk.
//   Ports:
//     clk      in   sampling clock
//     rst_n    in   asynchronous active-low reset, clears both stages to 0
//     i_d      in   W  asynchronous input
//     o_q      out  W  synchronised value (second stage)
//     o_q_next out  W  first stage: the value o_q loads on the next edge
// ---------------------------------------------------------------------------
module sw_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_q_next
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // NOTE: both stages are reset so the applied mode starts at a known value
  //       (STOP) instead of whatever the pins happen to show at power-up.
  // NOTE: non-blocking assignments make the two stages a true shift
  //       register; blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q      = r_sync;
  assign o_q_next = r_meta;

endmodule : sw_sync

// File: rtl/led_runner_ctrl.sv
// ---------------------------------------------------------------------------
// led_runner_ctrl
//   Running-light controller. A single lit LED rotates around an LED_W bank
//   at a rate chosen by the slide switches; DIR selects direction and HOLD
//   pauses the prescaler and the pattern.
//   Ports:
//     SCLK  in   system clock, rising edge
//     RSTN  in   asynchronous active-low reset
//     SW    in   2      mode select (async): 0 stop, 1..3 run at PERIOD_1..3
//     DIR   in   1      0 rotate toward MSB, 1 rotate toward LSB
//     HOLD  in   1      pause
//     LD    out  LED_W  LED pattern, exactly one bit set
//     TICK  out  1      one-cycle pulse coincident with each LD update
//     MODE  out  2      applied (synchronised) mode
// ---------------------------------------------------------------------------
module led_runner_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int LED_W    = 16,
  parameter int PERIOD_1 = 1000,
  parameter int PERIOD_2 = 500,
  parameter int PERIOD_3 = 200
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic [1:0]       SW,
  input  logic             DIR,
  input  logic             HOLD,
  output logic [LED_W-1:0] LD,
  output logic             TICK,
  output logic [1:0]       MODE
);

  localparam int MAX_P = max3(PERIOD_1, PERIOD_2, PERIOD_3);
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // Terminal counts (P-1) for each running mode.
  localparam logic [CNT_W-1:0] TC_1 = CNT_W'(PERIOD_1 - 1);
  localparam logic [CNT_W-1:0] TC_2 = CNT_W'(PERIOD_2 - 1);
  localparam logic [CNT_W-1:0] TC_3 = CNT_W'(PERIOD_3 - 1);

  logic [1:0]       w_sw_next;
  logic             w_mode_chg;
  state_e           w_state;
  logic [CNT_W-1:0] w_tc;
  logic [LED_W-1:0] w_ld_rot;
  logic [CNT_W-1:0] r_cnt;

  sw_sync #(
    .W (2)
  ) u_sw_sync (
    .clk      (SCLK),
    .rst_n    (RSTN),
    .i_d      (SW),
    .o_q      (MODE),
    .o_q_next (w_sw_next)
  );

  // A mode change is flagged in the cycle MODE itself is updated, so the
  // prescaler restarts on the same edge and the first step lands exactly P
  // cycles after MODE takes its new value.
  assign w_mode_chg = (w_sw_next != MODE);

  assign w_ld_rot = DIR ? {LD[0], LD[LED_W-1:1]}
                        : {LD[LED_W-2:0], LD[LED_W-1]};

  // NOTE: every signal gets a default before the decode so no path leaves it
  //       unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state = STOP;
    w_tc    = '0;
    if (MODE != MODE_STOP) begin
      w_state = HOLD ? PAUSE : RUN;
    end
    case (MODE)
      MODE_1:  w_tc = TC_1;
      MODE_2:  w_tc = TC_2;
      MODE_3:  w_tc = TC_3;
      default: w_tc = '0;
    endcase
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
      LD    <= {{(LED_W-1){1'b0}}, 1'b1};
      TICK  <= 1'b0;
    end else begin
      TICK <= 1'b0;
      if (w_mode_chg) begin
        // Mode change wins over a terminal count and over HOLD.
        r_cnt <= '0;
      end else begin
        case (w_state)
          RUN: begin
            if (r_cnt == w_tc) begin
              r_cnt <= '0;
              LD    <= w_ld_rot;
              TICK  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PAUSE: ; // counter and pattern frozen
          default: r_cnt <= '0; // STOP: pattern holds its last value
        endcase
      end
    end
  end

endmodule : led_runner_ctrl

// File: tb/tb_led_runner_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_runner_ctrl
//   Self-checking bench for led_runner_ctrl (default parameters). A reference
//   model tracks the lit LED as an index, the applied mode through a two-deep
//   queue of switch samples, and the cycles elapsed in the current period.
// ---------------------------------------------------------------------------
module tb_led_runner_ctrl;

  localparam int LED_W = 16;

  logic             SCLK;
  logic             RSTN;
  logic [1:0]       SW;
  logic             DIR;
  logic             HOLD;
  logic [LED_W-1:0] LD;
  logic             TICK;
  logic [1:0]       MODE;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_q[$];      // m_q[0] = applied mode, m_q[1] = mode arriving next edge
  int m_pos;       // index of the lit LED
  int m_elapsed;   // cycles counted toward the current period
  bit m_tick;

  led_runner_ctrl dut (
    .SCLK (SCLK),
    .RSTN (RSTN),
    .SW   (SW),
    .DIR  (DIR),
    .HOLD (HOLD),
    .LD   (LD),
    .TICK (TICK),
    .MODE (MODE)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int period(input int m);
    case (m)
      1:       return 1000;
      2:       return 500;
      3:       return 200;
      default: return 0;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] exp_ld();
    logic [LED_W-1:0] v;
    v = '0;
    v[m_pos] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_q       = '{0, 0};
    m_pos     = 0;
    m_elapsed = 0;
    m_tick    = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    int old_mode;
    int new_mode;
    if (!RSTN) begin
      model_reset();
    end else begin
      old_mode = m_q[0];
      new_mode = m_q[1];
      void'(m_q.pop_front());
      m_q.push_back(int'(SW));
      m_tick = 1'b0;
      if (new_mode != old_mode || old_mode == 0) begin
        m_elapsed = 0;
      end else if (!HOLD) begin
        m_elapsed++;
        if (m_elapsed == period(old_mode)) begin
          m_elapsed = 0;
          m_pos     = (m_pos + (DIR ? LED_W - 1 : 1)) % LED_W;
          m_tick    = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("LD", LD, exp_ld());
    check("TICK", TICK, m_tick);
    check("MODE", MODE, m_q[0]);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge SCLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Cycles until the DUT pulses TICK; returns budget if it never does.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!TICK && n < budget);
  endtask

  task automatic wait_mode(input int m, input string tag);
    int n;
    n = 0;
    while (MODE != 2'(m) && n < 10) begin
      step();
      n++;
    end
    check(tag, MODE, m);
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (m_elapsed != c && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    RSTN = 1'b0;
    model_reset();
    #1;
    check({tag, "_ld"}, LD, 16'h0001);
    check({tag, "_tick"}, TICK, 1'b0);
    check({tag, "_mode"}, MODE, 2'd0);
  endtask

  initial begin
    int n;
    logic [LED_W-1:0] snap;

    SW   = 2'd0;
    DIR  = 1'b0;
    HOLD = 1'b0;
    RSTN = 1'b0;
    model_reset();
    run(3);
    check("rst_ld", LD, 16'h0001);
    check("rst_tick", TICK, 1'b0);
    check("rst_mode", MODE, 2'd0);
    RSTN = 1'b1;
    run(5000);
    check("stop_after_rst_ld", LD, 16'h0001);

    // Mode 1 stepping up to LD=0x0010, then asynchronous reset mid-count.
    SW = 2'd1;
    run(2);
    check("sw_to_mode_2_edges", MODE, 2'd1);
    wait_tick(1100, n);
    check("m1_first_lat", n, 1000);
    check("m1_first_ld", LD, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      wait_tick(1100, n);
      check("m1_period", n, 1000);
    end
    check("m1_ld_before_rst", LD, 16'h0010);
    run(300);
    async_reset("midrun_rst");
    SW = 2'd0;
    run(2);
    RSTN = 1'b1;
    run(5000);
    check("stop_hold_ld", LD, 16'h0001);

    // Full wrap in mode 1.
    SW  = 2'd1;
    DIR = 1'b0;
    wait_mode(1, "wrap_mode");
    for (int k = 1; k <= 16; k++) begin
      wait_tick(1100, n);
      check("wrap_period", n, 1000);
      if (k == 15) check("wrap_ld_msb", LD, 16'h8000);
    end
    check("wrap_ld_lsb", LD, 16'h0001);

    // Mode 2 rotating toward LSB.
    SW  = 2'd2;
    DIR = 1'b1;
    wait_mode(2, "m2_mode");
    wait_tick(600, n);
    check("m2_first_lat", n, 500);
    check("m2_ld_wrap", LD, 16'h8000);
    wait_tick(600, n);
    check("m2_period", n, 500);
    check("m2_ld_next", LD, 16'h4000);

    // Mode change mid-count: 1 -> 3 at cnt 700.
    SW  = 2'd1;
    DIR = 1'b0;
    wait_mode(1, "chg_m1");
    wait_cnt(700);
    SW = 2'd3;
    wait_mode(3, "chg_m3");
    check("chg_no_step", TICK, 1'b0);
    wait_tick(300, n);
    check("chg_first_lat", n, 200);

    // Pause at cnt 150 for 37 cycles.
    wait_cnt(150);
    HOLD = 1'b1;
    snap = LD;
    run(37);
    check("pause_ld_frozen", LD, snap);
    HOLD = 1'b0;
    wait_tick(300, n);
    check("pause_resume_lat", n, 50);

    // HOLD in the terminal-count cycle suppresses that step.
    wait_cnt(199);
    snap = LD;
    HOLD = 1'b1;
    step();
    check("hold_tc_tick", TICK, 1'b0);
    check("hold_tc_ld", LD, snap);
    HOLD = 1'b0;
    step();
    check("hold_tc_resume", TICK, 1'b1);

    // Stop in mode 1 at LD=0x0040.
    SW = 2'd1;
    wait_mode(1, "stop_m1");
    n = 0;
    while (LD != 16'h0040 && n < 20) begin
      wait_tick(1100, snap);
      n++;
    end
    check("stop_reach_ld", LD, 16'h0040);
    SW = 2'd0;
    wait_mode(0, "stop_mode0");
    run(3000);
    check("stop_ld_held", LD, 16'h0040);
    SW = 2'd1;
    wait_mode(1, "restart_m1");
    wait_tick(1100, n);
    check("restart_lat", n, 1000);
    check("restart_ld", LD, 16'h0080);

    // Randomised segments of mode, direction and hold.
    for (int s = 0; s < 25; s++) begin
      SW   = 2'($urandom_range(0, 3));
      DIR  = 1'($urandom_range(0, 1));
      HOLD = ($urandom_range(0, 3) == 0);
      run($urandom_range(50, 700));
      if (s == 12) begin
        async_reset("rand_rst");
        run(2);
        RSTN = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_led_runner_ctrl
